// File: rtl/gate_sensor_decoder.sv
// rtl/gate_sensor_decoder.sv - parking gate beam-pair decoder producing inc/dec/error pulses
module gate_sensor_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic inc,
  output logic dec,
  output logic error,
  output logic busy
);

  // Counter must hold DEBOUNCE_CYCLES itself: the filtered bit flips on the
  // sample after DEBOUNCE_CYCLES consecutive differing samples have been seen.
  localparam int unsigned      CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [31:0]      DWELL_MAX = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN1,
    S_EN2,
    S_EN3,
    S_EX1,
    S_EX2,
    S_EX3,
    S_WAIT_CLEAR
  } state_t;

  // Bit 1 is beam A (street side), bit 0 is beam B (lot side).
  logic [1:0]       sync1_q, sync2_q, filt_q;
  logic [CNT_W-1:0] cnt_q [2];

  state_t      state_q, state_d;
  logic [31:0] dwell_q, dwell_d;
  logic        inc_d, dec_d, error_d;
  logic        tracking;
  logic [1:0]  p;

  assign p        = filt_q;
  assign tracking = (state_q != S_IDLE) && (state_q != S_WAIT_CLEAR);

  // Two-flop synchroniser followed by a per-beam debounce counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= {sensor_a, sensor_b};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Passage tracking: forward step, one-stage back-out, anything else is invalid.
  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        case (p)
          2'b10:   state_d = S_EN1;
          2'b01:   state_d = S_EX1;
          2'b11:   begin error_d = 1'b1; state_d = S_WAIT_CLEAR; end
          default: ;
        endcase
      end
      S_EN1: begin
        case (p)
          2'b10:   ;
          2'b11:   state_d = S_EN2;
          2'b00:   state_d = S_IDLE;
          default: begin error_d = 1'b1; state_d = S_WAIT_CLEAR; end
        endcase
      end
      S_EN2: begin
        case (p)
          2'b11:   ;
          2'b01:   state_d = S_EN3;
          2'b10:   state_d = S_EN1;
          default: begin error_d = 1'b1; state_d = S_WAIT_CLEAR; end
        endcase
      end
      S_EN3: begin
        case (p)
          2'b01:   ;
          2'b00:   begin inc_d = 1'b1; state_d = S_IDLE; end
          2'b11:   state_d = S_EN2;
          default: begin error_d = 1'b1; state_d = S_WAIT_CLEAR; end
        endcase
      end
      S_EX1: begin
        case (p)
          2'b01:   ;
          2'b11:   state_d = S_EX2;
          2'b00:   state_d = S_IDLE;
          default: begin error_d = 1'b1; state_d = S_WAIT_CLEAR; end
        endcase
      end
      S_EX2: begin
        case (p)
          2'b11:   ;
          2'b10:   state_d = S_EX3;
          2'b01:   state_d = S_EX1;
          default: begin error_d = 1'b1; state_d = S_WAIT_CLEAR; end
        endcase
      end
      S_EX3: begin
        case (p)
          2'b10:   ;
          2'b00:   begin dec_d = 1'b1; state_d = S_IDLE; end
          2'b11:   state_d = S_EX2;
          default: begin error_d = 1'b1; state_d = S_WAIT_CLEAR; end
        endcase
      end
      S_WAIT_CLEAR: begin
        if (p == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled passage times out only while it stays put; a real move wins.
    if (tracking && (state_d == state_q) && (dwell_q == DWELL_MAX)) begin
      error_d = 1'b1;
      state_d = S_WAIT_CLEAR;
    end

    if (!tracking || (state_d != state_q)) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + 32'd1;
    end
  end

  // FSM state, dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      inc     <= inc_d;
      dec     <= dec_d;
      error   <= error_d;
      busy    <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb/tb_gate_sensor_decoder.sv - directed bench with behavioural passage model for gate_sensor_decoder
module tb_gate_sensor_decoder;

  localparam int D = 2;
  localparam int T = 20;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_EXIT  = 2;
  localparam int M_WAIT  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;
  logic inc, dec, error, busy;

  gate_sensor_decoder #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .inc(inc), .dec(dec), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: raw history since reset, filtered pair, passage position.
  bit [1:0] raw_hist [0:4095];
  int       n = 0;
  bit [1:0] mf = 2'b00;
  int       last_chg [2];
  int       mmode = M_IDLE;
  int       mstage = 0;
  int       menter = 0;
  bit       m_inc = 0, m_dec = 0, m_err = 0, m_busy = 0;
  bit       model_ok = 0;

  // Scenario observations.
  int d_inc, d_dec, d_err, mi, md, me;
  int t_inc, t_dec, t_err, t_busy_rise, t_busy_fall;
  bit busy_prev = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Beam pattern at position k of a passage: 0 and 4 are clear, 1..3 the path.
  function automatic bit [1:0] path_pat(input int mode, input int k);
    if (k <= 0 || k >= 4) return 2'b00;
    if (k == 2) return 2'b11;
    if (mode == M_ENTRY) return (k == 1) ? 2'b10 : 2'b01;
    return (k == 1) ? 2'b01 : 2'b10;
  endfunction

  // Value the debouncer sees at edge m: raw captured two edges earlier, 0 before reset.
  function automatic bit sample_at(input int m, input int i);
    if (m - 2 < 1) return 1'b0;
    return raw_hist[m - 2][i];
  endfunction

  // A filtered bit flips when the last D+1 samples, all since its last change, disagree with it.
  function automatic bit filter_flips(input int i);
    if (n - D <= last_chg[i]) return 1'b0;
    for (int m = n - D; m <= n; m++) begin
      if (sample_at(m, i) == mf[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_fsm(input bit [1:0] p);
    m_inc = 0; m_dec = 0; m_err = 0;
    case (mmode)
      M_IDLE: begin
        if (p == 2'b10) begin mmode = M_ENTRY; mstage = 1; menter = n; end
        else if (p == 2'b01) begin mmode = M_EXIT; mstage = 1; menter = n; end
        else if (p == 2'b11) begin m_err = 1; mmode = M_WAIT; end
      end
      M_WAIT: begin
        if (p == 2'b00) mmode = M_IDLE;
      end
      default: begin
        if (p == path_pat(mmode, mstage)) begin
          if (n - menter == T) begin m_err = 1; mmode = M_WAIT; end
        end else if (p == path_pat(mmode, mstage + 1)) begin
          if (mstage == 3) begin
            if (mmode == M_ENTRY) m_inc = 1; else m_dec = 1;
            mmode = M_IDLE;
          end else begin
            mstage++; menter = n;
          end
        end else if (p == path_pat(mmode, mstage - 1)) begin
          if (mstage == 1) mmode = M_IDLE;
          else begin mstage--; menter = n; end
        end else begin
          m_err = 1; mmode = M_WAIT;
        end
      end
    endcase
    m_busy = (mmode != M_IDLE);
  endtask

  // Model advances on every rising edge, using the filtered pair from before the edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      n = 0; mf = 2'b00; last_chg[0] = 0; last_chg[1] = 0;
      mmode = M_IDLE; mstage = 0; menter = 0;
      m_inc = 0; m_dec = 0; m_err = 0; m_busy = 0;
      model_ok = 1;
    end else begin
      n++;
      raw_hist[n] = {sensor_a, sensor_b};
      model_fsm(mf);
      for (int i = 0; i < 2; i++) begin
        if (filter_flips(i)) begin
          mf[i] = ~mf[i];
          last_chg[i] = n;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("inc", inc, m_inc);
      chk("dec", dec, m_dec);
      chk("error", error, m_err);
      chk("busy", busy, m_busy);
      if (inc)   begin d_inc++; t_inc = cyc; end
      if (dec)   begin d_dec++; t_dec = cyc; end
      if (error) begin d_err++; t_err = cyc; end
      if (m_inc) mi++;
      if (m_dec) md++;
      if (m_err) me++;
      if (busy && !busy_prev && t_busy_rise < 0) t_busy_rise = cyc;
      if (!busy && busy_prev) t_busy_fall = cyc;
      busy_prev = busy;
    end
  end

  task automatic begin_scn();
    d_inc = 0; d_dec = 0; d_err = 0; mi = 0; md = 0; me = 0;
    t_inc = -1; t_dec = -1; t_err = -1; t_busy_rise = -1; t_busy_fall = -1;
  endtask

  task automatic hold(input bit [1:0] ab, input int cycles, output int t_first);
    @(negedge clk); #1;
    sensor_a = ab[1]; sensor_b = ab[0];
    t_first = cyc + 1;
    repeat (cycles - 1) @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset(input bit [1:0] ab_after);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_inc", inc, 0);
    chk("rst_dec", dec, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    sensor_a = ab_after[1]; sensor_b = ab_after[0];
  endtask

  task automatic chk_counts(input string tag, input int ei, input int ed, input int ee);
    chk({tag, "_inc_n"}, d_inc, ei);
    chk({tag, "_dec_n"}, d_dec, ed);
    chk({tag, "_err_n"}, d_err, ee);
    chk({tag, "_model_inc_n"}, mi, ei);
    chk({tag, "_model_dec_n"}, md, ed);
    chk({tag, "_model_err_n"}, me, ee);
  endtask

  initial begin
    int t10, t11, t01, t00, tx;
    begin_scn();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_inc", inc, 0);
    chk("reset_dec", dec, 0);
    chk("reset_error", error, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;

    // Clean entry.
    begin_scn();
    hold(2'b10, 8, t10); hold(2'b11, 8, tx); hold(2'b01, 8, tx); hold(2'b00, 12, t00);
    chk_counts("entry", 1, 0, 0);
    chk("entry_inc_latency", t_inc - t00, 5);
    chk("entry_busy_rise", t_busy_rise - t10, 5);
    chk("entry_busy_fall", t_busy_fall, t_inc);
    chk("entry_busy_end", busy, 0);

    // Clean exit.
    begin_scn();
    hold(2'b01, 8, tx); hold(2'b11, 8, tx); hold(2'b10, 8, tx); hold(2'b00, 12, t00);
    chk_counts("exit", 0, 1, 0);
    chk("exit_dec_latency", t_dec - t00, 5);
    chk("exit_busy_end", busy, 0);

    // Back-out after reaching both beams.
    begin_scn();
    hold(2'b10, 8, t10); hold(2'b11, 8, tx); hold(2'b10, 8, tx); hold(2'b00, 12, tx);
    chk_counts("backout", 0, 0, 0);
    chk("backout_busy_rise", t_busy_rise - t10, 5);
    chk("backout_busy_end", busy, 0);

    // One-cycle glitch on beam A.
    begin_scn();
    hold(2'b10, 1, tx); hold(2'b00, 12, tx);
    chk_counts("glitch", 0, 0, 0);
    chk("glitch_busy_rise", t_busy_rise, -1);

    // Invalid 10 -> 01 jump, then clear.
    begin_scn();
    hold(2'b10, 8, tx); hold(2'b01, 8, t01);
    chk("invalid_err_latency", t_err - t01, 5);
    chk("invalid_busy_wait", busy, 1);
    hold(2'b00, 12, tx);
    chk_counts("invalid", 0, 0, 1);
    chk("invalid_busy_end", busy, 0);

    // Stall in EN1 until timeout.
    begin_scn();
    hold(2'b10, 30, t10);
    chk("timeout_err_time", t_err - t10, 25);
    chk("timeout_err_after_en1", t_err - t_busy_rise, 20);
    chk("timeout_busy_held", busy, 1);
    hold(2'b00, 12, tx);
    chk_counts("timeout", 0, 0, 1);
    chk("timeout_busy_end", busy, 0);

    // Reset in EN2, then the remainder of the entry.
    begin_scn();
    hold(2'b10, 8, tx); hold(2'b11, 8, tx);
    pulse_reset(2'b01);
    repeat (7) @(negedge clk);
    #1;
    hold(2'b00, 12, tx);
    chk_counts("rstmid", 0, 0, 0);
    chk("rstmid_busy_end", busy, 0);

    // Both beams blocked from idle, and still blocked across a reset.
    begin_scn();
    hold(2'b11, 10, t11);
    chk("both_err_latency", t_err - t11, 5);
    pulse_reset(2'b11);
    repeat (9) @(negedge clk);
    #1;
    chk("both_busy_wait", busy, 1);
    hold(2'b00, 12, tx);
    chk_counts("both", 0, 0, 2);
    chk("both_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
